// File: rtl/psum_accumulator_pkg.sv
// Shared configuration for the partial-sum accumulator: geometry constants,
// accumulator row type and the controller state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
package psum_accumulator_pkg;

   // Array geometry seen from the accumulator side.
   localparam int SYS_COLS     = 4;
   localparam int P_BITWIDTH   = 16;
   localparam int ACC_BITWIDTH = 32;
   localparam int ACC_DEPTH    = 16;

   // One accumulator row, column c occupies bits [c*ACC_BITWIDTH +: ACC_BITWIDTH].
   typedef logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] acc_row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } psum_state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Row bus around the accumulator: upstream row strobe (no stall path) and the
// valid/ready drain toward the output-feature-map writer.
// Latency: n/a (wires only). Backpressure: out_ready only; input side cannot stall.
// Ports (slave = accumulator): in_valid/in_data in, out_valid/out_data/out_last out, out_ready in.
interface psum_accumulator_if #(
   parameter int SYS_COLS     = psum_accumulator_pkg::SYS_COLS,
   parameter int P_BITWIDTH   = psum_accumulator_pkg::P_BITWIDTH,
   parameter int ACC_BITWIDTH = psum_accumulator_pkg::ACC_BITWIDTH
) ();
   import psum_accumulator_pkg::*;

   logic                             in_valid;
   logic [SYS_COLS*P_BITWIDTH-1:0]   in_data;
   logic                             out_valid;
   logic                             out_ready;
   logic [SYS_COLS*ACC_BITWIDTH-1:0] out_data;
   logic                             out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output out_valid, out_data, out_last
   );

endinterface

// File: rtl/psum_accumulator_bank.sv
// psum_bank: DEPTH x row register array with one write port (overwrite or
// accumulate-in-place) and one combinational read port.
// Latency: write lands on the next edge; read is same-cycle. Backpressure: none.
// Ports: clk, rst (async high); wr_en_i, wr_acc_i, wr_addr_i, wr_data_i; rd_addr_i -> rd_data_o.
module psum_bank #(
   parameter int COLS         = psum_accumulator_pkg::SYS_COLS,
   parameter int ACC_BITWIDTH = psum_accumulator_pkg::ACC_BITWIDTH,
   parameter int DEPTH        = psum_accumulator_pkg::ACC_DEPTH,
   parameter int ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en_i,
   input  logic                               wr_acc_i,
   input  logic [ADDR_W-1:0]                  wr_addr_i,
   input  logic [COLS-1:0][ACC_BITWIDTH-1:0]  wr_data_i,
   input  logic [ADDR_W-1:0]                  rd_addr_i,
   output logic [COLS-1:0][ACC_BITWIDTH-1:0]  rd_data_o
);
   import psum_accumulator_pkg::*;

   logic [COLS-1:0][ACC_BITWIDTH-1:0] bank_q [DEPTH];
   logic [COLS-1:0][ACC_BITWIDTH-1:0] wr_row_d;

   // Per-column add wraps modulo 2^ACC_BITWIDTH; signedness is irrelevant
   // to two's-complement addition so plain vectors are used.
   always_comb begin
      wr_row_d = wr_data_i;
      if (wr_acc_i) begin
         for (int c = 0; c < COLS; c++) begin
            wr_row_d[c] = bank_q[wr_addr_i][c] + wr_data_i[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            bank_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         bank_q[wr_addr_i] <= wr_row_d;
      end
   end

   assign rd_data_o = bank_q[rd_addr_i];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates cfg_k_tiles passes of cfg_rows rows from the systolic array, then drains them.
// Latency: first drained row is valid 1 cycle after the final input row.
// Backpressure: out_ready stalls the drain (data held); input side has no stall, strays set err_drop.
// Ports: clk, rst (async high); cfg_load/cfg_rows/cfg_k_tiles job setup; bus (slave) carries
// in_valid/in_data and out_valid/out_ready/out_data/out_last; busy; err_drop (sticky).
// Build option: define PSUM_RELU_EN to clamp negative output columns to zero (bank untouched).
module psum_accumulator #(
   parameter int SYS_COLS     = psum_accumulator_pkg::SYS_COLS,
   parameter int P_BITWIDTH   = psum_accumulator_pkg::P_BITWIDTH,
   parameter int ACC_BITWIDTH = psum_accumulator_pkg::ACC_BITWIDTH,
   parameter int ACC_DEPTH    = psum_accumulator_pkg::ACC_DEPTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_load,
   input  logic [$clog2(ACC_DEPTH+1)-1:0] cfg_rows,
   input  logic [7:0]                     cfg_k_tiles,
   psum_accumulator_if.slave              bus,
   output logic                           busy,
   output logic                           err_drop
);
   import psum_accumulator_pkg::*;

   localparam int CNT_W  = $clog2(ACC_DEPTH+1);
   localparam int ADDR_W = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

   typedef logic [SYS_COLS-1:0][ACC_BITWIDTH-1:0] row_t;

   psum_state_t state_q, state_d;
   logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] rows_q, rows_d;
   logic [7:0]       tile_cnt_q, tile_cnt_d;
   logic [7:0]       k_tiles_q, k_tiles_d;
   logic             err_q, err_d;

   logic [SYS_COLS-1:0][P_BITWIDTH-1:0] in_row;
   row_t ext_row;
   row_t rd_row;
   row_t out_row;
   logic bank_wr_en;
   logic bank_wr_acc;
   logic wr_last_row;
   logic wr_last_tile;
   logic rd_last_row;

   assign in_row = bus.in_data;

   // Sign-extend every column of the incoming row to accumulator width.
   always_comb begin
      ext_row = '0;
      for (int c = 0; c < SYS_COLS; c++) begin
         ext_row[c] = ACC_BITWIDTH'(signed'(in_row[c]));
      end
   end

   assign wr_last_row  = (wr_ptr_q == rows_q - CNT_W'(1));
   assign wr_last_tile = (tile_cnt_q == k_tiles_q - 8'd1);
   assign rd_last_row  = (rd_ptr_q == rows_q - CNT_W'(1));

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      rows_d      = rows_q;
      tile_cnt_d  = tile_cnt_q;
      k_tiles_d   = k_tiles_q;
      err_d       = err_q;
      bank_wr_en  = 1'b0;
      bank_wr_acc = 1'b0;

      case (state_q)
         IDLE: begin
            // A zero-sized job would never finish; treat it as no request.
            if (cfg_load && (cfg_rows != '0) && (cfg_k_tiles != 8'd0)) begin
               rows_d     = cfg_rows;
               k_tiles_d  = cfg_k_tiles;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               tile_cnt_d = 8'd0;
               state_d    = ACCUM;
            end
         end
         ACCUM: begin
            if (bus.in_valid) begin
               bank_wr_en  = 1'b1;
               // First pass overwrites, so stale rows from a previous job never leak.
               bank_wr_acc = (tile_cnt_q != 8'd0);
               if (wr_last_row) begin
                  wr_ptr_d   = '0;
                  tile_cnt_d = tile_cnt_q + 8'd1;
                  if (wr_last_tile) begin
                     rd_ptr_d = '0;
                     state_d  = DRAIN;
                  end
               end else begin
                  wr_ptr_d = wr_ptr_q + CNT_W'(1);
               end
            end
         end
         DRAIN: begin
            if (bus.out_ready) begin
               if (rd_last_row) begin
                  rd_ptr_d = '0;
                  state_d  = IDLE;
               end else begin
                  rd_ptr_d = rd_ptr_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Upstream cannot be stalled, so rows arriving outside ACCUM are lost; flag it.
      if (bus.in_valid && (state_q != ACCUM)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rows_q     <= '0;
         tile_cnt_q <= 8'd0;
         k_tiles_q  <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rows_q     <= rows_d;
         tile_cnt_q <= tile_cnt_d;
         k_tiles_q  <= k_tiles_d;
         err_q      <= err_d;
      end
   end

   psum_bank #(
      .COLS         (SYS_COLS),
      .ACC_BITWIDTH (ACC_BITWIDTH),
      .DEPTH        (ACC_DEPTH),
      .ADDR_W       (ADDR_W)
   ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bank_wr_en),
      .wr_acc_i  (bank_wr_acc),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i (ext_row),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o (rd_row)
   );

   // Output row straight from the bank register; it only changes when rd_ptr moves.
   always_comb begin
      out_row = '0;
      for (int c = 0; c < SYS_COLS; c++) begin
`ifdef PSUM_RELU_EN
         out_row[c] = rd_row[c][ACC_BITWIDTH-1] ? '0 : rd_row[c];
`else
         out_row[c] = rd_row[c];
`endif
      end
   end

   assign bus.out_valid = (state_q == DRAIN);
   assign bus.out_last  = (state_q == DRAIN) && rd_last_row;
   assign bus.out_data  = out_row;
   assign busy          = (state_q != IDLE);
   assign err_drop      = err_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: table of accumulation jobs checked through a
// scoreboard queue, plus hand-written sequences for reset, stray rows and abort-by-reset.
// Runs with or without PSUM_RELU_EN.
module tb_psum_accumulator;
   import psum_accumulator_pkg::*;

   localparam int OW = SYS_COLS*ACC_BITWIDTH;
   localparam int IW = SYS_COLS*P_BITWIDTH;
   localparam int CW = $clog2(ACC_DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_load;
   logic [CW-1:0] cfg_rows;
   logic [7:0]    cfg_k_tiles;
   logic          busy;
   logic          err_drop;

   always #5 clk = ~clk;

   psum_accumulator_if bus ();

   psum_accumulator dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_rows    (cfg_rows),
      .cfg_k_tiles (cfg_k_tiles),
      .bus         (bus),
      .busy        (busy),
      .err_drop    (err_drop)
   );

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   typedef struct {
      int         rows;
      int         k;
      int         mode;
      logic [3:0] rdy;
      int         exp_last_c0;
   } job_t;

   exp_t          sb[$];
   int            n_cmp = 0;
   int            n_err = 0;
   logic [3:0]    rdy_mask = 4'b1111;
   logic [1:0]    rdy_idx = 2'd0;
   logic [OW-1:0] held;
   logic          held_vld = 1'b0;
   logic [OW-1:0] last_row_seen;
   logic [OW-1:0] last_job_row0;

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [ACC_BITWIDTH-1:0] relu(input logic signed [ACC_BITWIDTH-1:0] v);
`ifdef PSUM_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   // Column value fed on pass p, row r, column c for each stimulus pattern.
   function automatic int stim(input int mode, input int p, input int r, input int c);
      case (mode)
         0:       return (r == 0) ? (c + 1) : -(c + 1);
         1:       return 5;
         2:       return (c == 0) ? ((p == 0) ? -100 : 30) : 0;
         3:       return r*16 + c;
         4:       return (r + 1)*(c + 1)*((p == 0) ? 1 : -3);
         default: return 7;
      endcase
   endfunction

   // Downstream ready follows a repeating 4-cycle pattern chosen per job.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rdy_mask[rdy_idx];
         rdy_idx = rdy_idx + 2'd1;
      end
   end

   // Drain monitor: pops the scoreboard on every handshake and checks hold during stalls.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid) begin
         if (held_vld) chk("stall_hold", bus.out_data, held);
         if (bus.out_ready) begin
            held_vld = 1'b0;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL extra_row: got %h expected none", bus.out_data);
            end else begin
               e = sb.pop_front();
               chk("row_data", bus.out_data, e.data);
               chk1("row_last", bus.out_last, e.last);
            end
            if (bus.out_last) last_row_seen = bus.out_data;
         end else begin
            held     = bus.out_data;
            held_vld = 1'b1;
         end
      end
   end

   task automatic run_job(input job_t j);
      logic signed [ACC_BITWIDTH-1:0] acc [ACC_DEPTH][SYS_COLS];
      logic [IW-1:0] row;
      exp_t e;
      int   v;
      int   n;
      rdy_mask      = j.rdy;
      last_row_seen = {SYS_COLS{32'hDEAD_BEEF}};
      @(posedge clk);
      #1;
      cfg_rows    = CW'(j.rows);
      cfg_k_tiles = 8'(j.k);
      cfg_load    = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      chk1("busy_after_load", busy, 1'b1);
      for (int p = 0; p < j.k; p++) begin
         for (int r = 0; r < j.rows; r++) begin
            for (int c = 0; c < SYS_COLS; c++) begin
               v = stim(j.mode, p, r, c);
               row[c*P_BITWIDTH +: P_BITWIDTH] = P_BITWIDTH'(v);
               acc[r][c] = (p == 0) ? ACC_BITWIDTH'(v) : acc[r][c] + ACC_BITWIDTH'(v);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = row;
            if (p == j.k - 1 && r == j.rows - 1) begin
               chk1("no_early_out", bus.out_valid, 1'b0);
               for (int rr = 0; rr < j.rows; rr++) begin
                  for (int c = 0; c < SYS_COLS; c++) begin
                     e.data[c*ACC_BITWIDTH +: ACC_BITWIDTH] = relu(acc[rr][c]);
                  end
                  e.last = (rr == j.rows - 1);
                  if (rr == 0) last_job_row0 = e.data;
                  sb.push_back(e);
               end
            end
            @(posedge clk);
            #1;
         end
      end
      bus.in_valid = 1'b0;
      chk1("first_out_latency", bus.out_valid, 1'b1);
      n = 0;
      while (busy && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk1("drain_done", busy, 1'b0);
      chk_int("sb_empty", sb.size(), 0);
      chk("last_row_c0", OW'(last_row_seen[ACC_BITWIDTH-1:0]), OW'(relu(j.exp_last_c0)));
   endtask

   job_t jobs[5];

   initial begin
      jobs[0] = '{2,  1, 0, 4'b1111, -1};   // sign extension, k=1
      jobs[1] = '{3,  3, 1, 4'b1111, 15};   // three-pass accumulation
      jobs[2] = '{1,  2, 2, 4'b1111, -70};  // negative result (ReLU target)
      jobs[3] = '{4,  1, 3, 4'b1001, 48};   // ready 1,0,0,1 stalls
      jobs[4] = '{16, 2, 4, 4'b1011, -32};  // full depth, stalls, negatives

      rst          = 1'b1;
      cfg_load     = 1'b0;
      cfg_rows     = '0;
      cfg_k_tiles  = 8'd0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      #23;
      chk1("rst_out_valid", bus.out_valid, 1'b0);
      chk1("rst_out_last", bus.out_last, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_err_drop", err_drop, 1'b0);
      chk("rst_out_data", bus.out_data, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) run_job(jobs[i]);

      // Stray row in IDLE and zero-field cfg_load.
      chk1("err_clear_before", err_drop, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = {SYS_COLS{16'h1234}};
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk1("err_drop_idle", err_drop, 1'b1);
      chk1("idle_after_drop", busy, 1'b0);
      cfg_rows = CW'(0); cfg_k_tiles = 8'd3; cfg_load = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      chk1("rows0_ignored", busy, 1'b0);
      cfg_rows = CW'(2); cfg_k_tiles = 8'd0; cfg_load = 1'b1;
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      chk1("k0_ignored", busy, 1'b0);
      chk1("idle_no_out_valid", bus.out_valid, 1'b0);
      chk("bank_unchanged", bus.out_data, last_job_row0);
      chk1("err_drop_sticky", err_drop, 1'b1);

      // Abort mid-ACCUM with reset, then a fresh job must show no stale data.
      @(posedge clk);
      #1;
      cfg_rows = CW'(4); cfg_k_tiles = 8'd1; cfg_load = 1'b1;
      @(posedge clk);
      #1;
      cfg_load     = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = {SYS_COLS{16'h0055}};
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk1("busy_mid_accum", busy, 1'b1);
      rst = 1'b1;
      #3;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_out_valid", bus.out_valid, 1'b0);
      chk1("abort_err_drop", err_drop, 1'b0);
      chk("abort_out_data", bus.out_data, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_job('{1, 1, 5, 4'b1111, 7});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
